// File: rtl/sram_march_tester.sv
// SRAM self-test engine: fill, read-modify-write, then check every word of an
// external asynchronous SRAM. Latches address/expected/actual data of the first
// mismatch. Only SRAM master while busy.
//
// state    | meaning
// S_IDLE   | waiting for start after reset
// S_FILL   | write the fill pattern to every word
// S_MODIFY | read each word and write back the modified value
// S_CHECK  | read each word and compare against the expected value
// S_DONE   | result valid; waiting for the next start
module sram_march_tester #(
  parameter int unsigned          DW          = 16,
  parameter int unsigned          AW          = 21,
  parameter logic [AW-1:0]        END_ADDR    = 21'h07FFFF,
  parameter int unsigned          WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 slow,
  output logic [AW-1:0]        sram_a,
  inout  wire  [DW-1:0]        sram_d,
  output logic                 sram_we_n,
  output logic [DW/8-1:0]      sram_be_n,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           phase,
  output logic [AW-1:0]        fail_addr,
  output logic [DW-1:0]        fail_exp,
  output logic [DW-1:0]        fail_act
);

  localparam int unsigned NB = DW / 8;
  localparam logic [DW-1:0] PAT = {(DW/2){2'b01}};
  localparam logic [DW-1:0] LANE0 = DW'(8'hFF);
  localparam logic [NB-1:0] BE_LANE0 = ~NB'(1);
  // Access sub-step counter: 0 setup, 1..W_LAST WE low (or read wait), REC recovery.
  localparam logic [4:0] W_LAST = 5'(WAIT_CYCLES + 1);
  localparam logic [4:0] REC    = 5'(WAIT_CYCLES + 2);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MODIFY, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            tog_q, tog_d, slow_q, slow_d, rd_q, rd_d;
  logic [1:0]      mode_q, mode_d, phase_q, phase_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [AW-1:0]   a_q, a_d, fail_addr_q, fail_addr_d;
  logic [DW-1:0]   dout_q, dout_d, fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
  logic            we_n_q, we_n_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [NB-1:0]   be_n_q, be_n_d;
  logic            tick, last;
  logic [DW-1:0]   exp_w;

  function automatic logic [DW-1:0] a2d(input logic [AW-1:0] a);
    logic [DW+AW-1:0] ext;
    ext = {{DW{1'b0}}, a};
    return ext[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] fill_data(input logic [1:0] m, input logic [AW-1:0] a);
    return (m == 2'd1) ? (a2d(a) ^ PAT) : PAT;
  endfunction

  function automatic logic [DW-1:0] mod_data(input logic [1:0] m, input logic [DW-1:0] d);
    case (m)
      2'd1:    return ~d;
      2'd2:    return ~PAT;
      default: return d + PAT;
    endcase
  endfunction

  function automatic logic [DW-1:0] chk_data(input logic [1:0] m, input logic [AW-1:0] a);
    case (m)
      2'd1:    return ~(a2d(a) ^ PAT);
      2'd2:    return PAT ^ LANE0;
      default: return PAT + PAT;
    endcase
  endfunction

  assign sram_d    = sram_we_n ? {DW{1'bz}} : dout_q;
  assign sram_a    = a_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign phase     = phase_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;

  // Next-state logic: start handling, then one step of the access sequencer per tick.
  always_comb begin
    state_d = state_q; tog_d = ~tog_q; slow_d = slow_q; rd_d = rd_q;
    mode_d = mode_q; phase_d = phase_q; cnt_d = cnt_q; a_d = a_q; dout_d = dout_q;
    we_n_d = we_n_q; be_n_d = be_n_q; busy_d = busy_q; done_d = done_q; pass_d = pass_q;
    fail_addr_d = fail_addr_q; fail_exp_d = fail_exp_q; fail_act_d = fail_act_q;
    tick  = !hold && (!slow_q || tog_q);
    last  = (a_q == END_ADDR);
    exp_w = chk_data(mode_q, a_q);
    if (!hold && start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d = S_FILL; mode_d = mode; slow_d = slow; a_d = '0;
      dout_d = fill_data(mode, '0); cnt_d = '0; rd_d = 1'b0; we_n_d = 1'b1;
      be_n_d = '0; busy_d = 1'b1; done_d = 1'b0; pass_d = 1'b0; phase_d = 2'd1;
      fail_addr_d = '0; fail_exp_d = '0; fail_act_d = '0;
    end else if (tick) begin
      case (state_q)
        S_FILL, S_MODIFY: begin
          if (state_q == S_MODIFY && rd_q) begin
            // Read half of the modify access; the sample tick doubles as write setup.
            if (cnt_q == W_LAST) begin
              dout_d = mod_data(mode_q, sram_d);
              rd_d   = 1'b0;
              cnt_d  = '0;
              if (mode_q == 2'd2) be_n_d = BE_LANE0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else if (cnt_q == 5'd0) begin
            we_n_d = 1'b0;
            cnt_d  = 5'd1;
          end else if (cnt_q == W_LAST) begin
            we_n_d = 1'b1;
            cnt_d  = REC;
          end else if (cnt_q == REC) begin
            cnt_d  = '0;
            be_n_d = '0;
            rd_d   = (state_q == S_MODIFY);
            if (last) begin
              a_d     = '0;
              rd_d    = 1'b1;
              state_d = (state_q == S_FILL) ? S_MODIFY : S_CHECK;
              phase_d = (state_q == S_FILL) ? 2'd2 : 2'd3;
            end else begin
              a_d    = a_q + AW'(1);
              dout_d = fill_data(mode_q, a_q + AW'(1));
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_CHECK: begin
          if (cnt_q == W_LAST) begin
            cnt_d = '0;
            if (sram_d != exp_w || last) begin
              state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0; phase_d = 2'd0;
              be_n_d  = '1;
              pass_d  = (sram_d == exp_w);
              if (sram_d != exp_w) begin
                fail_addr_d = a_q; fail_exp_d = exp_w; fail_act_d = sram_d;
              end
            end else begin
              a_d = a_q + AW'(1);
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; synchronous reset aborts any access in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; tog_q <= 1'b0; slow_q <= 1'b0; rd_q <= 1'b0;
      mode_q <= '0; phase_q <= '0; cnt_q <= '0; a_q <= '0; dout_q <= '0;
      we_n_q <= 1'b1; be_n_q <= '1; busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0;
      fail_addr_q <= '0; fail_exp_q <= '0; fail_act_q <= '0;
    end else begin
      state_q <= state_d; tog_q <= tog_d; slow_q <= slow_d; rd_q <= rd_d;
      mode_q <= mode_d; phase_q <= phase_d; cnt_q <= cnt_d; a_q <= a_d; dout_q <= dout_d;
      we_n_q <= we_n_d; be_n_q <= be_n_d; busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d;
      fail_addr_q <= fail_addr_d; fail_exp_q <= fail_exp_d; fail_act_q <= fail_act_d;
    end
  end

endmodule

// File: tb/tb_sram_march_tester.sv
// Bench for sram_march_tester: behavioural async SRAM with fault knobs, WE pulse
// monitor, and a result scoreboard popped when the DUT reports done.
module tb_sram_march_tester;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int WC = 2;

  typedef struct {
    logic        pass;
    logic [7:0]  addr;
    logic [15:0] fexp;
    logic [15:0] fact;
    int          fill_n;
    int          mod_n;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, hold = 1'b0, start = 1'b0, slow = 1'b0;
  logic [1:0] mode = 2'd0;
  wire  [DW-1:0] sram_d;
  logic [AW-1:0] sram_a, fail_addr;
  logic sram_we_n, busy, done, pass;
  logic [1:0] sram_be_n, phase;
  logic [DW-1:0] fail_exp, fail_act;

  int total = 0, bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sram_march_tester #(.DW(DW), .AW(AW), .END_ADDR(8'd15), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .hold(hold), .start(start), .mode(mode), .slow(slow),
    .sram_a(sram_a), .sram_d(sram_d), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .busy(busy), .done(done), .pass(pass), .phase(phase),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // SRAM model: stuck-at-0 on bit 3 of address 7, optional byte-enable ignore.
  logic [15:0] mem [0:255];
  logic stuck_en = 1'b0, ignore_be = 1'b0;
  logic [15:0] rd_val;
  always_comb begin
    rd_val = mem[sram_a];
    if (stuck_en && sram_a == 8'd7) rd_val[3] = 1'b0;
  end
  assign sram_d = sram_we_n ? rd_val : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_we_n) begin
      if (ignore_be || !sram_be_n[0]) mem[sram_a][7:0]  <= sram_d[7:0];
      if (ignore_be || !sram_be_n[1]) mem[sram_a][15:8] <= sram_d[15:8];
    end
  end

  // WE pulse monitor: counts pulses per phase, checks stability and width.
  int fill_we = 0, mod_we = 0, chk_we = 0, total_we = 0, low_cnt = 0, exp_we_clk = 3;
  logic prev_we = 1'b1, skip_width = 1'b0;
  logic [AW-1:0] cap_a;
  logic [15:0] cap_d;
  always @(negedge clk) begin
    if (prev_we && !sram_we_n) begin
      total_we++;
      case (phase)
        2'd1: fill_we++;
        2'd2: mod_we++;
        2'd3: chk_we++;
        default: ;
      endcase
      cap_a = sram_a; cap_d = sram_d; low_cnt = 1;
    end else if (!sram_we_n) begin
      low_cnt++;
      chk("we_addr_stable", 32'(sram_a), 32'(cap_a));
      chk("we_data_stable", 32'(sram_d), 32'(cap_d));
    end else if (!prev_we && !skip_width && !reset) begin
      chk("we_width", 32'(low_cnt), 32'(exp_we_clk));
    end
    prev_we = sram_we_n;
  end

  task automatic run_test(input logic [1:0] m, input logic s, input logic poke, input exp_t e_in);
    int f0, m0, c0;
    exp_t e;
    exp_we_clk = (WC + 1) * (s ? 2 : 1);
    f0 = fill_we; m0 = mod_we; c0 = chk_we;
    @(negedge clk);
    mode = m; slow = s; start = 1'b1;
    sb_q.push_back(e_in);
    @(negedge clk);
    start = 1'b0;
    chk("start_phase", 32'(phase), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_faddr_clr", 32'(fail_addr), 32'd0);
    chk("start_fdata_clr", {fail_exp, fail_act}, 32'd0);
    if (poke) begin
      for (int i = 0; i < 4000 && phase != 2'd2; i++) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_phase", 32'(phase), 32'd2);
      chk("busy_start_busy", 32'(busy), 32'd1);
    end
    for (int i = 0; i < 6000 && !done; i++) @(negedge clk);
    chk("done", 32'(done), 32'd1);
    e = sb_q.pop_front();
    chk("pass", 32'(pass), 32'(e.pass));
    chk("busy_end", 32'(busy), 32'd0);
    chk("be_end", 32'(sram_be_n), 32'h3);
    chk("fail_addr", 32'(fail_addr), 32'(e.addr));
    chk("fail_exp", 32'(fail_exp), 32'(e.fexp));
    chk("fail_act", 32'(fail_act), 32'(e.fact));
    chk("fill_we_n", 32'(fill_we - f0), 32'(e.fill_n));
    chk("mod_we_n", 32'(mod_we - m0), 32'(e.mod_n));
    chk("chk_we_n", 32'(chk_we - c0), 32'd0);
  endtask

  initial begin
    exp_t e;
    int tw;
    logic [31:0] snap;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(sram_we_n), 32'd1);
    chk("rst_be", 32'(sram_be_n), 32'h3);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_flags", {busy, done, pass, phase}, 32'd0);
    chk("rst_fail", {fail_addr, fail_exp}, 32'd0);

    // mode 0, ideal SRAM
    e = '{1'b1, 8'd0, 16'h0, 16'h0, 16, 16};
    run_test(2'd0, 1'b0, 1'b0, e);
    for (int i = 0; i < 16; i++) chk("mem_mode0", 32'(mem[i]), 32'hAAAA);

    // mode 1, stuck bit 3 at address 7
    stuck_en = 1'b1;
    e = '{1'b0, 8'd7, ~(16'd7 ^ 16'h5555), 16'hAAA5, 16, 16};
    run_test(2'd1, 1'b0, 1'b0, e);
    tw = total_we;
    repeat (40) @(negedge clk);
    chk("no_wr_after_fail", 32'(total_we), 32'(tw));
    chk("idle_after_fail", 32'(busy), 32'd0);
    stuck_en = 1'b0;

    // restart from a failed DONE, start pulsed while busy, slow clock enable
    e = '{1'b1, 8'd0, 16'h0, 16'h0, 16, 16};
    run_test(2'd1, 1'b1, 1'b1, e);

    // mode 2, byte lanes honoured
    e = '{1'b1, 8'd0, 16'h0, 16'h0, 16, 16};
    run_test(2'd2, 1'b0, 1'b0, e);
    for (int i = 0; i < 4; i++) chk("mem_mode2", 32'(mem[i]), 32'h55AA);

    // mode 2, model ignores byte enables
    ignore_be = 1'b1;
    e = '{1'b0, 8'd0, 16'h55AA, 16'hAAAA, 16, 16};
    run_test(2'd2, 1'b0, 1'b0, e);
    ignore_be = 1'b0;

    // mode 3 behaves as mode 0, slow
    e = '{1'b1, 8'd0, 16'h0, 16'h0, 16, 16};
    run_test(2'd3, 1'b1, 1'b0, e);
    chk("mem_mode3", 32'(mem[15]), 32'hAAAA);

    // hold mid-write, then reset mid-check
    skip_width = 1'b1;
    @(negedge clk);
    mode = 2'd0; slow = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && !(sram_a == 8'd3 && !sram_we_n); i++) @(negedge clk);
    chk("reach_write3", 32'(sram_we_n), 32'd0);
    hold = 1'b1;
    snap = {sram_a, sram_we_n, sram_be_n, busy, done, pass, phase, sram_d};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_frozen", {sram_a, sram_we_n, sram_be_n, busy, done, pass, phase, sram_d}, snap);
    end
    hold = 1'b0;
    for (int i = 0; i < 4000 && phase != 2'd3; i++) @(negedge clk);
    chk("reach_check", 32'(phase), 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_we", 32'(sram_we_n), 32'd1);
    chk("rst_mid_be", 32'(sram_be_n), 32'h3);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);

    // start with hold=1 is ignored
    hold = 1'b1; start = 1'b1;
    @(negedge clk);
    hold = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("hold_start_busy", 32'(busy), 32'd0);
    chk("hold_start_phase", 32'(phase), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
